// File: rtl/cva5_types.sv
// Shared divide-unit types: operand packet, attributes, instruction id and sequencer FSM states.
package cva5_types;
    localparam int MAX_IDS      = 8;
    localparam int LOG2_MAX_IDS = $clog2(MAX_IDS);

    typedef logic [LOG2_MAX_IDS-1:0] id_t;

    typedef struct packed {
        logic remainder_op;
        logic negate_result;
        logic reuse_result;
        id_t  id;
    } div_attributes_t;

    typedef struct packed {
        logic [31:0]     unsigned_dividend;
        logic [31:0]     unsigned_divisor;
        logic [4:0]      dividend_clz;
        logic [4:0]      divisor_clz;
        logic            divisor_is_zero;
        div_attributes_t attr;
    } div_fifo_inputs_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WB
    } div_seq_state_t;

    localparam logic [31:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;
endpackage

// File: rtl/cva5_fifo.sv
// Power-of-two circular FIFO; full is taken from the pre-pop count, so a push is refused while full.
module cva5_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic                  full
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;
    logic                  do_push, do_pop;

    always_comb begin
        valid    = (count_q != '0);
        full     = (count_q == (PTR_W+1)'(FIFO_DEPTH));
        do_push  = push & ~full;
        do_pop   = pop & valid;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        data_out = mem[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= data_in;
    end
endmodule

// File: rtl/div_sequencer.sv
// Sequences buffered divide operands through an iterative core, with divide-by-zero and
// result-reuse fast paths. Reuse is built only when CVA5_DIV_REUSE_EN is defined.
module div_sequencer
    import cva5_types::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  div_fifo_inputs_t in_data,
    output logic             in_ready,
    output logic             core_start,
    output logic [31:0]      core_dividend,
    output logic [31:0]      core_divisor,
    output logic [4:0]       core_dividend_clz,
    output logic [4:0]       core_divisor_clz,
    input  logic             core_done,
    input  logic [31:0]      core_quotient,
    input  logic [31:0]      core_remainder,
    output logic             wb_valid,
    output id_t              wb_id,
    output logic [31:0]      wb_data,
    input  logic             wb_ack
);
    localparam int FIFO_W = $bits(div_fifo_inputs_t);

    div_seq_state_t   state_q, state_d;
    logic [FIFO_W-1:0] fifo_dout;
    div_fifo_inputs_t head;
    logic             fifo_valid, fifo_full, fifo_push, fifo_pop;
    logic             core_accept, reuse_hit, fast_path;
    logic [31:0]      reuse_quo, reuse_rem, fast_result;

    logic        core_start_q, core_start_d;
    logic [31:0] core_dividend_q, core_dividend_d;
    logic [31:0] core_divisor_q, core_divisor_d;
    logic [4:0]  core_dividend_clz_q, core_dividend_clz_d;
    logic [4:0]  core_divisor_clz_q, core_divisor_clz_d;
    logic        act_rem_op_q, act_rem_op_d;
    logic        act_negate_q, act_negate_d;
    id_t         wb_id_q, wb_id_d;
    logic [31:0] wb_data_q, wb_data_d;

    function automatic logic [31:0] select_result(input logic [31:0] quo, input logic [31:0] rem,
                                                  input logic rem_op, input logic negate);
        logic [31:0] raw;
        raw = rem_op ? rem : quo;
        return negate ? (~raw + 32'd1) : raw;
    endfunction

    assign head      = fifo_dout;
    assign fifo_push = in_valid & in_ready;

    cva5_fifo #(
        .DATA_WIDTH(FIFO_W),
        .FIFO_DEPTH(DEPTH)
    ) operand_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .data_in  (in_data),
        .data_out (fifo_dout),
        .valid    (fifo_valid),
        .full     (fifo_full)
    );

`ifdef CVA5_DIV_REUSE_EN
    logic [31:0] saved_quo_q, saved_quo_d;
    logic [31:0] saved_rem_q, saved_rem_d;
    logic        saved_valid_q, saved_valid_d;

    // Only real core completions refresh the saved pair; divide-by-zero leaves it intact.
    always_comb begin
        saved_quo_d   = saved_quo_q;
        saved_rem_d   = saved_rem_q;
        saved_valid_d = saved_valid_q;
        if (core_accept) begin
            saved_quo_d   = core_quotient;
            saved_rem_d   = core_remainder;
            saved_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            saved_quo_q   <= '0;
            saved_rem_q   <= '0;
            saved_valid_q <= 1'b0;
        end else begin
            saved_quo_q   <= saved_quo_d;
            saved_rem_q   <= saved_rem_d;
            saved_valid_q <= saved_valid_d;
        end
    end

    assign reuse_hit = head.attr.reuse_result & saved_valid_q;
    assign reuse_quo = saved_quo_q;
    assign reuse_rem = saved_rem_q;
`else
    logic unused_reuse;
    assign unused_reuse = head.attr.reuse_result;
    assign reuse_hit    = 1'b0;
    assign reuse_quo    = '0;
    assign reuse_rem    = '0;
`endif

    always_comb begin
        fast_path = head.divisor_is_zero | reuse_hit;
        if (head.divisor_is_zero)
            fast_result = select_result(DIV_ZERO_QUOTIENT, head.unsigned_dividend,
                                        head.attr.remainder_op, head.attr.negate_result);
        else
            fast_result = select_result(reuse_quo, reuse_rem,
                                        head.attr.remainder_op, head.attr.negate_result);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fifo_valid) state_d = fast_path ? WB : RUN;
            RUN:     if (core_done) state_d = WB;
            WB:      if (wb_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = ~fifo_full;
        fifo_pop    = (state_q == IDLE) & fifo_valid;
        core_accept = (state_q == RUN) & core_done;
        wb_valid    = (state_q == WB);
    end

    always_comb begin
        core_start_d        = 1'b0;
        core_dividend_d     = core_dividend_q;
        core_divisor_d      = core_divisor_q;
        core_dividend_clz_d = core_dividend_clz_q;
        core_divisor_clz_d  = core_divisor_clz_q;
        act_rem_op_d        = act_rem_op_q;
        act_negate_d        = act_negate_q;
        wb_id_d             = wb_id_q;
        wb_data_d           = wb_data_q;
        if (fifo_pop) begin
            act_rem_op_d = head.attr.remainder_op;
            act_negate_d = head.attr.negate_result;
            wb_id_d      = head.attr.id;
            if (fast_path) begin
                wb_data_d = fast_result;
            end else begin
                core_start_d        = 1'b1;
                core_dividend_d     = head.unsigned_dividend;
                core_divisor_d      = head.unsigned_divisor;
                core_dividend_clz_d = head.dividend_clz;
                core_divisor_clz_d  = head.divisor_clz;
            end
        end
        if (core_accept)
            wb_data_d = select_result(core_quotient, core_remainder, act_rem_op_q, act_negate_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_start_q        <= 1'b0;
            core_dividend_q     <= '0;
            core_divisor_q      <= '0;
            core_dividend_clz_q <= '0;
            core_divisor_clz_q  <= '0;
            act_rem_op_q        <= 1'b0;
            act_negate_q        <= 1'b0;
            wb_id_q             <= '0;
            wb_data_q           <= '0;
        end else begin
            core_start_q        <= core_start_d;
            core_dividend_q     <= core_dividend_d;
            core_divisor_q      <= core_divisor_d;
            core_dividend_clz_q <= core_dividend_clz_d;
            core_divisor_clz_q  <= core_divisor_clz_d;
            act_rem_op_q        <= act_rem_op_d;
            act_negate_q        <= act_negate_d;
            wb_id_q             <= wb_id_d;
            wb_data_q           <= wb_data_d;
        end
    end

    assign core_start        = core_start_q;
    assign core_dividend     = core_dividend_q;
    assign core_divisor      = core_divisor_q;
    assign core_dividend_clz = core_dividend_clz_q;
    assign core_divisor_clz  = core_divisor_clz_q;
    assign wb_id             = wb_id_q;
    assign wb_data           = wb_data_q;
endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: core path, divide-by-zero, reuse, negation, back-pressure, reset.
module tb_div_sequencer;
    import cva5_types::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    div_fifo_inputs_t in_data = '0;
    logic             in_ready;
    logic             core_start;
    logic [31:0]      core_dividend, core_divisor;
    logic [4:0]       core_dividend_clz, core_divisor_clz;
    logic             core_done = 1'b0;
    logic [31:0]      core_quotient = '0, core_remainder = '0;
    logic             wb_valid;
    id_t              wb_id;
    logic [31:0]      wb_data;
    logic             wb_ack = 1'b0;

    int total = 0;
    int bad   = 0;

    div_sequencer #(.DEPTH(2)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_ready          (in_ready),
        .core_start        (core_start),
        .core_dividend     (core_dividend),
        .core_divisor      (core_divisor),
        .core_dividend_clz (core_dividend_clz),
        .core_divisor_clz  (core_divisor_clz),
        .core_done         (core_done),
        .core_quotient     (core_quotient),
        .core_remainder    (core_remainder),
        .wb_valid          (wb_valid),
        .wb_id             (wb_id),
        .wb_data           (wb_data),
        .wb_ack            (wb_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        logic acc;
        acc = in_valid & in_ready;
        @(posedge clk);
        #1;
        if (acc) in_valid = 1'b0;
    endtask

    function automatic div_fifo_inputs_t pkt(input logic [31:0] dvd, input logic [31:0] dvs,
                                             input logic [4:0] dclz, input logic [4:0] sclz,
                                             input logic zero, input logic rem, input logic neg,
                                             input logic reuse, input id_t id);
        div_fifo_inputs_t p;
        p.unsigned_dividend      = dvd;
        p.unsigned_divisor       = dvs;
        p.dividend_clz           = dclz;
        p.divisor_clz            = sclz;
        p.divisor_is_zero        = zero;
        p.attr.remainder_op      = rem;
        p.attr.negate_result     = neg;
        p.attr.reuse_result      = reuse;
        p.attr.id                = id;
        return p;
    endfunction

    // Offer one packet; returns in the cycle that pops it (FIFO empty and sequencer idle).
    task automatic push(input div_fifo_inputs_t p);
        in_data  = p;
        in_valid = 1'b1;
        step();
    endtask

    task automatic ack(input string tag);
        wb_ack = 1'b1;
        step();
        wb_ack = 1'b0;
        check({tag, "_valid_after_ack"}, 32'(wb_valid), 32'd0);
    endtask

    task automatic expect_fast(input string tag, input logic [31:0] exp_data, input id_t exp_id);
        check({tag, "_no_start_pop"}, 32'(core_start), 32'd0);
        step();
        check({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
        check({tag, "_no_start"}, 32'(core_start), 32'd0);
        check({tag, "_data"}, wb_data, exp_data);
        check({tag, "_id"}, 32'(wb_id), 32'(exp_id));
        ack(tag);
    endtask

    // Core responds ten cycles after core_start; every start seen on the way is counted.
    task automatic expect_core(input string tag, input logic [31:0] q, input logic [31:0] r,
                               input logic [31:0] exp_data, input id_t exp_id);
        int starts;
        check({tag, "_no_start_pop"}, 32'(core_start), 32'd0);
        step();
        check({tag, "_start"}, 32'(core_start), 32'd1);
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            starts += int'(core_start);
        end
        core_done      = 1'b1;
        core_quotient  = q;
        core_remainder = r;
        check({tag, "_valid_in_done_cycle"}, 32'(wb_valid), 32'd0);
        step();
        core_done      = 1'b0;
        core_quotient  = 32'hDEAD_BEEF;
        core_remainder = 32'hDEAD_BEEF;
        check({tag, "_extra_starts"}, 32'(starts), 32'd0);
        check({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
        check({tag, "_data"}, wb_data, exp_data);
        check({tag, "_id"}, 32'(wb_id), 32'(exp_id));
        step();
        check({tag, "_data_held"}, wb_data, exp_data);
        ack(tag);
    endtask

    initial begin
        id_t         ids  [4];
        logic [31:0] dvds [4];
        int          cnt;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_core_start", 32'(core_start), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_id", 32'(wb_id), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_core_dividend", core_dividend, 32'd0);
        rst_n = 1'b1;
        step();

        // Stray core_done and wb_ack while idle do nothing.
        core_done = 1'b1;
        wb_ack    = 1'b1;
        step();
        core_done = 1'b0;
        wb_ack    = 1'b0;
        step();
        check("idle_stray_wb_valid", 32'(wb_valid), 32'd0);
        check("idle_stray_core_start", 32'(core_start), 32'd0);

        // 20 / 6 through the core.
        push(pkt(32'd20, 32'd6, 5'd27, 5'd29, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5));
        step();
        check("op1_dividend", core_dividend, 32'd20);
        check("op1_divisor", core_divisor, 32'd6);
        check("op1_dividend_clz", 32'(core_dividend_clz), 32'd27);
        check("op1_divisor_clz", 32'(core_divisor_clz), 32'd29);
        repeat (2) begin
            in_valid = 1'b0;
        end
        // Restart the op from its pop cycle view: rewind not possible, so finish it by hand.
        for (int i = 0; i < 9; i++) step();
        core_done      = 1'b1;
        core_quotient  = 32'd3;
        core_remainder = 32'd2;
        step();
        core_done = 1'b0;
        check("op1_wb_valid", 32'(wb_valid), 32'd1);
        check("op1_wb_id", 32'(wb_id), 32'd5);
        check("op1_wb_data", wb_data, 32'd3);
        ack("op1");

        // Divide by zero, quotient and remainder flavours.
        push(pkt(32'h1234, 32'd0, 5'd19, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2));
        expect_fast("dz_quo", 32'hFFFF_FFFF, 3'd2);
        push(pkt(32'h1234, 32'd0, 5'd19, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3));
        expect_fast("dz_rem", 32'h0000_1234, 3'd3);

        // Reuse of the 20/6 result (remainder 2).
        push(pkt(32'd20, 32'd6, 5'd27, 5'd29, 1'b0, 1'b1, 1'b0, 1'b1, 3'd6));
`ifdef CVA5_DIV_REUSE_EN
        expect_fast("reuse", 32'd2, 3'd6);
`else
        expect_core("reuse", 32'd3, 32'd9, 32'd9, 3'd6);
`endif

        // Negated quotient.
        push(pkt(32'd21, 32'd7, 5'd27, 5'd29, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7));
        expect_core("neg", 32'd3, 32'd0, 32'hFFFF_FFFD, 3'd7);

        // Four back-to-back divide-by-zero pushes with writeback stalled.
        ids  = '{3'd1, 3'd2, 3'd3, 3'd4};
        dvds = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int k = 0; k < 3; k++) begin
            in_data  = pkt(dvds[k], 32'd0, 5'd0, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, ids[k]);
            in_valid = 1'b1;
            step();
        end
        check("bp_in_ready_full", 32'(in_ready), 32'd0);
        in_data  = pkt(dvds[3], 32'd0, 5'd0, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, ids[3]);
        in_valid = 1'b1;
        step();
        step();
        check("bp_fourth_held", 32'(in_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            cnt = 0;
            while (!wb_valid && cnt < 20) begin
                step();
                cnt++;
            end
            check("bp_wb_valid", 32'(wb_valid), 32'd1);
            check("bp_data", wb_data, dvds[k]);
            check("bp_id", 32'(wb_id), 32'(ids[k]));
            step();
            step();
            check("bp_data_stable", wb_data, dvds[k]);
            check("bp_id_stable", 32'(wb_id), 32'(ids[k]));
            wb_ack = 1'b1;
            step();
            wb_ack = 1'b0;
        end
        check("bp_all_accepted", 32'(in_valid), 32'd0);

        // Reset while the core is running; a late core_done must be dropped.
        push(pkt(32'd100, 32'd9, 5'd25, 5'd28, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
        step();
        check("rr_start", 32'(core_start), 32'd1);
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("rr_in_reset_start", 32'(core_start), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        core_done     = 1'b1;
        core_quotient = 32'd11;
        step();
        core_done = 1'b0;
        check("rr_wb_valid", 32'(wb_valid), 32'd0);
        check("rr_core_start", 32'(core_start), 32'd0);
        check("rr_in_ready", 32'(in_ready), 32'd1);
        check("rr_wb_data", wb_data, 32'd0);
        step();
        step();
        check("rr_no_writeback", 32'(wb_valid), 32'd0);

        // Saved result cleared by reset, so reuse runs the core.
        push(pkt(32'd50, 32'd5, 5'd26, 5'd29, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3));
        expect_core("reuse_after_rst", 32'h55, 32'd0, 32'h55, 3'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
